// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer between EX/MEM and a byte-enabled data memory port.
// Optional feature: define MISALIGN_SPLIT_EN to split misaligned accesses into two word beats.
module load_store_unit #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wd,
    output logic                  stall,
    output logic                  done,
    output logic                  err,
    output logic [DATA_W-1:0]     rd,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC0 = 2'd1;
    localparam logic [1:0] ACC1 = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wd_q, lo_q, rd_q;
    logic [2:0]            f3_q;
    logic                  load_q, split_q, bad_q;

    logic                  req, half_in, word_in, legal_f3, misal_bad, split_in, bad_in;
    logic [1:0]            off_in;
    logic [3:0]            lanes;
    logic [7:0]            be8;
    logic [2*DATA_W-1:0]   st_pair, ld_pair;
    logic [DATA_W-1:0]     ld_word, ld_res;
    logic [DM_ADDRESS-1:0] base_addr;

    assign req = req_valid & (MemRead | MemWrite);

    always_comb begin
        off_in  = addr[1:0];
        half_in = (Funct3[1:0] == 2'b01);
        word_in = (Funct3 == 3'b010);
        if (MemRead)
            legal_f3 = Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else
            legal_f3 = Funct3 inside {3'b000, 3'b001, 3'b010};
`ifdef MISALIGN_SPLIT_EN
        misal_bad = 1'b0;
        split_in  = (half_in && off_in == 2'd3) || (word_in && off_in != 2'd0);
`else
        misal_bad = (half_in && off_in[0]) || (word_in && off_in != 2'd0);
        split_in  = 1'b0;
`endif
        bad_in = !legal_f3 || misal_bad;
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = req ? (bad_in ? FIN : ACC0) : IDLE;
            ACC0:    state_d = split_q ? ACC1 : FIN;
            ACC1:    state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    // Lanes and data are formed over a double word; the upper half is beat 1.
    always_comb begin
        case (f3_q[1:0])
            2'b00:   lanes = 4'b0001;
            2'b01:   lanes = 4'b0011;
            default: lanes = 4'b1111;
        endcase
        be8       = {4'b0000, lanes} << addr_q[1:0];
        st_pair   = {{DATA_W{1'b0}}, wd_q} << {addr_q[1:0], 3'b000};
        ld_pair   = split_q ? {mem_rdata, lo_q} : {{DATA_W{1'b0}}, mem_rdata};
        ld_word   = ld_pair[{addr_q[1:0], 3'b000} +: DATA_W];
        base_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
        case (f3_q)
            3'b000:  ld_res = {{(DATA_W-8){ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_res = {{(DATA_W-16){ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_res = {{(DATA_W-8){1'b0}}, ld_word[7:0]};
            3'b101:  ld_res = {{(DATA_W-16){1'b0}}, ld_word[15:0]};
            default: ld_res = ld_word;
        endcase
    end

    // Strobes are masked by reset so a pending beat 1 is never issued.
    always_comb begin
        mem_addr = '0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        mem_be   = '0;
        mem_wd   = '0;
        if (!reset && (state_q == ACC0 || state_q == ACC1)) begin
            mem_re = load_q;
            mem_we = !load_q;
            if (state_q == ACC0) begin
                mem_addr = base_addr;
                mem_be   = load_q ? 4'b0000 : be8[3:0];
                mem_wd   = load_q ? '0 : st_pair[DATA_W-1:0];
            end else begin
                mem_addr = base_addr + DM_ADDRESS'(4);
                mem_be   = load_q ? 4'b0000 : be8[7:4];
                mem_wd   = load_q ? '0 : st_pair[2*DATA_W-1:DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            f3_q    <= '0;
            load_q  <= 1'b0;
            split_q <= 1'b0;
            bad_q   <= 1'b0;
            lo_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                addr_q  <= addr;
                wd_q    <= wd;
                f3_q    <= Funct3;
                load_q  <= MemRead;
                split_q <= split_in && !bad_in;
                bad_q   <= bad_in;
            end
            if (state_q == ACC1)
                lo_q <= mem_rdata;
            if (state_q == FIN && load_q && !bad_q)
                rd_q <= ld_res;
        end
    end

    assign stall = (state_q != FIN) && ((state_q != IDLE) || req);
    assign done  = (state_q == FIN);
    assign err   = done && bad_q;
    assign rd    = rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit; vector table plus scoreboard, with reset corner sequences.
// Build with MISALIGN_SPLIT_EN defined to exercise the split-access vectors.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset, req_valid, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  addr, mem_addr;
    logic [31:0] wd, rd, mem_wd, mem_rdata;
    logic        stall, done, err, mem_re, mem_we;
    logic [3:0]  mem_be;
    logic        mem_init;

    always #5 clk = ~clk;

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .Funct3(Funct3), .addr(addr), .wd(wd),
        .stall(stall), .done(done), .err(err), .rd(rd), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be), .mem_wd(mem_wd),
        .mem_rdata(mem_rdata)
    );

    // Byte-enabled memory with one-cycle read latency.
    logic [31:0] mem [0:127];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
            mem[8]  <= 32'h44332211;
            mem[9]  <= 32'h88776655;
            mem[16] <= 32'h5A5A5A5A;
            mem[17] <= 32'hCAFEF00D;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_wd[8*b +: 8];
            mem_rdata <= mem_re ? mem[mem_addr[8:2]] : 32'h0;
        end
    end

    typedef struct {
        logic ld; logic st; logic [2:0] f3; logic [8:0] a; logic [31:0] d;
        logic e_err; int unsigned e_cyc; int unsigned e_nb;
        logic [8:0] e_a0; logic [3:0] e_be0; logic [31:0] e_wd0;
        logic [8:0] e_a1; logic [3:0] e_be1; logic [31:0] e_wd1;
        logic upd; logic [31:0] e_rd;
    } vec_t;

    vec_t        tbl[$];
    vec_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_rd = 32'h0;

    function automatic vec_t vld(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] r,
                                 input int unsigned cyc, input logic [8:0] a0, input logic [8:0] a1,
                                 input logic both);
        vec_t v;
        v = '{ld: 1'b1, st: both, f3: f3, a: a, d: 32'h0, e_err: 1'b0, e_cyc: cyc, e_nb: cyc - 1,
              e_a0: a0, e_be0: 4'h0, e_wd0: 32'h0, e_a1: a1, e_be1: 4'h0, e_wd1: 32'h0,
              upd: 1'b1, e_rd: r};
        return v;
    endfunction

    function automatic vec_t vst(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d,
                                 input int unsigned cyc, input logic [8:0] a0, input logic [3:0] be0,
                                 input logic [31:0] wd0, input logic [8:0] a1, input logic [3:0] be1,
                                 input logic [31:0] wd1);
        vec_t v;
        v = '{ld: 1'b0, st: 1'b1, f3: f3, a: a, d: d, e_err: 1'b0, e_cyc: cyc, e_nb: cyc - 1,
              e_a0: a0, e_be0: be0, e_wd0: wd0, e_a1: a1, e_be1: be1, e_wd1: wd1,
              upd: 1'b0, e_rd: 32'h0};
        return v;
    endfunction

    function automatic vec_t vbad(input logic isld, input logic [2:0] f3, input logic [8:0] a);
        vec_t v;
        v = '{ld: isld, st: !isld, f3: f3, a: a, d: 32'h12345678, e_err: 1'b1, e_cyc: 1, e_nb: 0,
              e_a0: 9'h0, e_be0: 4'h0, e_wd0: 32'h0, e_a1: 9'h0, e_be1: 4'h0, e_wd1: 32'h0,
              upd: 1'b0, e_rd: 32'h0};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drives one request in the current IDLE cycle and checks it through to the rd update.
    task automatic run_vec(input vec_t v, input int idx);
        vec_t        e;
        logic [8:0]  ba [2];
        logic [3:0]  bbe [2];
        logic [31:0] bwd [2];
        int unsigned nb, cyc;
        logic        got_done, got_err, strobe_ok;
        string       tag;
        tag = $sformatf("v%0d", idx);
        sb.push_back(v);
        req_valid = 1'b1; MemRead = v.ld; MemWrite = v.st;
        Funct3 = v.f3; addr = v.a; wd = v.d;
        #1 chk({tag, " stall@T"}, {31'b0, stall}, 32'h1);
        nb = 0; cyc = 0; got_done = 1'b0; got_err = 1'b0; strobe_ok = 1'b1;
        ba = '{9'h0, 9'h0}; bbe = '{4'h0, 4'h0}; bwd = '{32'h0, 32'h0};
        while (!got_done && cyc < 8) begin
            @(posedge clk); #1;
            req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
            cyc++;
            if (mem_re || mem_we) begin
                if (nb < 2) begin ba[nb] = mem_addr; bbe[nb] = mem_be; bwd[nb] = mem_wd; end
                if (!(mem_re === v.ld && mem_we === !v.ld)) strobe_ok = 1'b0;
                nb++;
            end
            if (done) begin
                got_done = 1'b1;
                got_err  = err;
                chk({tag, " stall@done"}, {31'b0, stall}, 32'h0);
            end else begin
                chk({tag, " stall busy"}, {31'b0, stall}, 32'h1);
            end
        end
        e = sb.pop_front();
        if (!got_done) begin
            tests++; fails++;
            $display("FAIL %s timeout: no done within %0d cycles", tag, cyc);
        end else begin
            chk({tag, " done latency"}, cyc, e.e_cyc);
            chk({tag, " err"}, {31'b0, got_err}, {31'b0, e.e_err});
            chk({tag, " beats"}, nb, e.e_nb);
            chk({tag, " strobe kind"}, {31'b0, strobe_ok}, 32'h1);
            if (e.e_nb >= 1) chk({tag, " addr0"}, {23'b0, ba[0]}, {23'b0, e.e_a0});
            if (e.e_nb >= 2) chk({tag, " addr1"}, {23'b0, ba[1]}, {23'b0, e.e_a1});
            if (!e.ld && e.e_nb >= 1) begin
                chk({tag, " be0"}, {28'b0, bbe[0]}, {28'b0, e.e_be0});
                chk({tag, " wd0"}, bwd[0], e.e_wd0);
            end
            if (!e.ld && e.e_nb >= 2) begin
                chk({tag, " be1"}, {28'b0, bbe[1]}, {28'b0, e.e_be1});
                chk({tag, " wd1"}, bwd[1], e.e_wd1);
            end
        end
        @(posedge clk); #1;
        if (e.upd) model_rd = e.e_rd;
        chk({tag, " rd"}, rd, model_rd);
        chk({tag, " done pulse width"}, {31'b0, done}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Funct3 = 3'b0; addr = 9'h0; wd = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; mem_init = 1'b0;
        #1;
        chk("reset rd", rd, 32'h0);
        chk("reset flags", {28'b0, stall, done, err, mem_re}, 32'h0);
        chk("reset mem", {mem_we, mem_be, mem_addr}, 32'h0);
        chk("reset mem_wd", mem_wd, 32'h0);

        // Aligned and in-word traffic, common to both builds.
        tbl.push_back(vst(3'b010, 9'h010, 32'hDEADBEEF, 2, 9'h010, 4'b1111, 32'hDEADBEEF, 9'h0, 4'h0, 32'h0));
        tbl.push_back(vld(3'b010, 9'h010, 32'hDEADBEEF, 2, 9'h010, 9'h0, 1'b0));
        tbl.push_back(vst(3'b000, 9'h013, 32'h000000A5, 2, 9'h010, 4'b1000, 32'hA5000000, 9'h0, 4'h0, 32'h0));
        tbl.push_back(vld(3'b000, 9'h013, 32'hFFFFFFA5, 2, 9'h010, 9'h0, 1'b0));
        tbl.push_back(vld(3'b100, 9'h013, 32'h000000A5, 2, 9'h010, 9'h0, 1'b0));
        tbl.push_back(vld(3'b001, 9'h012, 32'hFFFFA5AD, 2, 9'h010, 9'h0, 1'b0));
        tbl.push_back(vld(3'b101, 9'h012, 32'h0000A5AD, 2, 9'h010, 9'h0, 1'b0));
        tbl.push_back(vld(3'b100, 9'h011, 32'h000000BE, 2, 9'h010, 9'h0, 1'b0));
        tbl.push_back(vst(3'b001, 9'h016, 32'hFFFF1234, 2, 9'h014, 4'b1100, 32'h12340000, 9'h0, 4'h0, 32'h0));
        tbl.push_back(vld(3'b010, 9'h014, 32'h12340000, 2, 9'h014, 9'h0, 1'b1));
        tbl.push_back(vst(3'b000, 9'h015, 32'h00000077, 2, 9'h014, 4'b0010, 32'h00007700, 9'h0, 4'h0, 32'h0));
        tbl.push_back(vld(3'b000, 9'h015, 32'h00000077, 2, 9'h014, 9'h0, 1'b0));
        tbl.push_back(vbad(1'b1, 3'b011, 9'h010));
        tbl.push_back(vbad(1'b0, 3'b100, 9'h010));
        tbl.push_back(vbad(1'b1, 3'b111, 9'h010));
        tbl.push_back(vst(3'b001, 9'h012, 32'h0000CAFE, 2, 9'h010, 4'b1100, 32'hCAFE0000, 9'h0, 4'h0, 32'h0));
        tbl.push_back(vld(3'b001, 9'h012, 32'hFFFFCAFE, 2, 9'h010, 9'h0, 1'b0));
`ifdef MISALIGN_SPLIT_EN
        tbl.push_back(vld(3'b010, 9'h022, 32'h66554433, 3, 9'h020, 9'h024, 1'b0));
        tbl.push_back(vld(3'b010, 9'h021, 32'h55443322, 3, 9'h020, 9'h024, 1'b0));
        tbl.push_back(vst(3'b001, 9'h1FF, 32'h0000BEEF, 3, 9'h1FC, 4'b1000, 32'hEF000000, 9'h000, 4'b0001, 32'h000000BE));
        tbl.push_back(vld(3'b001, 9'h1FF, 32'hFFFFBEEF, 3, 9'h1FC, 9'h000, 1'b0));
        tbl.push_back(vld(3'b001, 9'h011, 32'hFFFFFEBE, 2, 9'h010, 9'h0, 1'b0));
        tbl.push_back(vld(3'b001, 9'h013, 32'h000000CA, 3, 9'h010, 9'h014, 1'b0));
        tbl.push_back(vst(3'b010, 9'h022, 32'hAABBCCDD, 3, 9'h020, 4'b1100, 32'hCCDD0000, 9'h024, 4'b0011, 32'h0000AABB));
        tbl.push_back(vld(3'b010, 9'h020, 32'hCCDD2211, 2, 9'h020, 9'h0, 1'b0));
        tbl.push_back(vld(3'b010, 9'h024, 32'h8877AABB, 2, 9'h024, 9'h0, 1'b0));
`else
        tbl.push_back(vbad(1'b1, 3'b010, 9'h002));
        tbl.push_back(vbad(1'b0, 3'b001, 9'h1FF));
        tbl.push_back(vbad(1'b1, 3'b001, 9'h011));
        tbl.push_back(vbad(1'b1, 3'b101, 9'h013));
        tbl.push_back(vbad(1'b0, 3'b010, 9'h012));
        tbl.push_back(vld(3'b010, 9'h020, 32'h44332211, 2, 9'h020, 9'h0, 1'b0));
`endif
        foreach (tbl[i]) run_vec(tbl[i], i);

        // req_valid without a memory op must not stall or start an access.
        req_valid = 1'b1;
        #1 chk("noop stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        chk("noop idle", {29'b0, done, mem_re, mem_we}, 32'h0);
        req_valid = 1'b0;

        // Reset in the middle of a store: later beats never reach memory.
        req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b010; wd = 32'h11223344;
`ifdef MISALIGN_SPLIT_EN
        addr = 9'h041;
        @(posedge clk); #1;
        req_valid = 1'b0; MemWrite = 1'b0;
        chk("rst acc0 beat", {mem_we, mem_be, mem_addr}, {18'b0, 1'b1, 4'b1110, 9'h040});
        chk("rst acc0 wd", mem_wd, 32'h22334400);
        @(posedge clk); #1;
        chk("rst acc1 beat", {31'b0, mem_we}, 32'h1);
        chk("rst acc1 addr", {23'b0, mem_addr}, 32'h044);
`else
        addr = 9'h040;
        @(posedge clk); #1;
        req_valid = 1'b0; MemWrite = 1'b0;
        chk("rst acc0 beat", {mem_we, mem_be, mem_addr}, {18'b0, 1'b1, 4'b1111, 9'h040});
`endif
        reset = 1'b1;
        #1 chk("rst masks strobe", {30'b0, mem_we, mem_re}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        model_rd = 32'h0;
        chk("post-rst flags", {28'b0, stall, done, err, mem_re}, 32'h0);
        chk("post-rst mem", {mem_we, mem_be, mem_addr}, 32'h0);
        chk("post-rst mem_wd", mem_wd, 32'h0);
        chk("post-rst rd", rd, 32'h0);
        #1;
`ifdef MISALIGN_SPLIT_EN
        run_vec(vld(3'b010, 9'h040, 32'h2233445A, 2, 9'h040, 9'h0, 1'b0), 100);
`else
        run_vec(vld(3'b010, 9'h040, 32'h5A5A5A5A, 2, 9'h040, 9'h0, 1'b0), 100);
`endif
        run_vec(vld(3'b010, 9'h044, 32'hCAFEF00D, 2, 9'h044, 9'h0, 1'b0), 101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
